e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the P6 five-stage pipeline, sitting alongside the E-stage ALU directly upstream of the M stage. It executes mult, multu, div, divu, mthi and mtlo, and holds the HI/LO register pair. Its result output (`MDOut`) feeds the E/M pipeline register for mfhi/mflo. Its `Busy` output goes to the hazard unit, which stalls the D stage while a multi-cycle operation is in flight.

---
 rtl/e_mdu.sv | 184 ++++++++++++++++++
 tb/tb_e_mdu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit holding the HI/LO pair
// Optional macro MDU_ZERO_LATENCY_EN: arithmetic commits at the Start edge, Busy tied low.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        ReadHi,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] squot;
  logic [31:0] srem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_wr;
  logic        is_arith;

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'd0, A} * {32'd0, B};
  assign squot = $signed(A) / $signed(B);
  assign srem  = $signed(A) % $signed(B);

  assign is_arith = Start && (MDUOp >= OP_MULT) && (MDUOp <= OP_DIVU);
  assign MDOut    = ReadHi ? HI : LO;

  // res_wr stays low for divide-by-zero so HI/LO keep their old values
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
    case (MDUOp)
      OP_MULT: begin
        {res_hi, res_lo} = sprod;
        res_wr = 1'b1;
      end
      OP_MULTU: begin
        {res_hi, res_lo} = uprod;
        res_wr = 1'b1;
      end
      OP_DIV: begin
        if (B != '0) begin
          res_wr = 1'b1;
          if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            res_lo = 32'h8000_0000;
            res_hi = '0;
          end else begin
            res_lo = squot;
            res_hi = srem;
          end
        end
      end
      OP_DIVU: begin
        if (B != '0) begin
          res_wr = 1'b1;
          res_lo = A / B;
          res_hi = A % B;
        end
      end
      default: ;
    endcase
  end

`ifdef MDU_ZERO_LATENCY_EN

  assign Busy = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (Start) begin
      if (is_arith) begin
        if (res_wr) begin
          HI <= res_hi;
          LO <= res_lo;
        end
      end else if (MDUOp == OP_MTHI) begin
        HI <= A;
      end else if (MDUOp == OP_MTLO) begin
        LO <= A;
      end
    end
  end

`else

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               pend_wr;
  logic               accept;
  logic               commit;
  logic               is_mul;

  assign is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign Busy   = (state == S_BUSY);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_arith) begin
          accept     = 1'b1;
          state_next = S_BUSY;
          cnt_next   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      S_BUSY: begin
        if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Start during a busy period is dropped entirely, mt ops included
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end
      if (commit && pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else if (state == S_IDLE && Start && MDUOp == OP_MTHI) begin
        HI <= A;
      end else if (state == S_IDLE && Start && MDUOp == OP_MTLO) begin
        LO <= A;
      end
    end
  end

`endif

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu: vector table, corner sequences, random vs model
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        read_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[14];

  e_mdu dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (start),
    .MDUOp  (mdu_op),
    .A      (a),
    .B      (b),
    .ReadHi (read_hi),
    .Busy   (busy),
    .HI     (hi),
    .LO     (lo),
    .MDOut  (md_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_busy(input logic [2:0] op);
`ifdef MDU_ZERO_LATENCY_EN
    return 0;
`else
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
`endif
  endfunction

  // Reference model: plain 64-bit arithmetic on the architectural rules
  task automatic model_apply(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    longint q;
    longint r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd1: begin p = 64'(sx * sy); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd4: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output int cycles);
    @(negedge clk);
    start  = 1'b1;
    mdu_op = op;
    a      = x;
    b      = y;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
    cycles = 0;
    while (busy && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{3'd6, 32'h0000_0000, 32'h0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2]  = '{3'd2, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[3]  = '{3'd3, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2, 32'h0000_0001, 32'h7FFF_FFFC};
    vecs[5]  = '{3'd5, 32'h0000_0011, 32'h0, 32'h0000_0011, 32'h7FFF_FFFC};
    vecs[6]  = '{3'd6, 32'h0000_0022, 32'h0, 32'h0000_0011, 32'h0000_0022};
    vecs[7]  = '{3'd3, 32'h0000_0005, 32'h0, 32'h0000_0011, 32'h0000_0022};
    vecs[8]  = '{3'd4, 32'h0000_0005, 32'h0, 32'h0000_0011, 32'h0000_0022};
    vecs[9]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[10] = '{3'd0, 32'h1234_5678, 32'h9, 32'h0000_0000, 32'h8000_0000};
    vecs[11] = '{3'd7, 32'h1234_5678, 32'h9, 32'h0000_0000, 32'h8000_0000};
    vecs[12] = '{3'd1, 32'h0000_0006, 32'h7, 32'h0000_0000, 32'h0000_002A};
    vecs[13] = '{3'd5, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 32'h0000_002A};

    reset = 1'b1; start = 1'b0; mdu_op = 3'd0; a = '0; b = '0; read_hi = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_mdout", md_out, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
      check($sformatf("vec%0d_busy", i), 32'(cyc), 32'(exp_busy(vecs[i].op)));
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    read_hi = 1'b1; #1;
    check("mdout_hi", md_out, 32'hDEAD_BEEF);
    read_hi = 1'b0; #1;
    check("mdout_lo", md_out, 32'h0000_002A);

    // Reset three cycles into a division: result must be discarded
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check("rstmid_late_busy", {31'd0, busy}, 32'd0);
    check("rstmid_late_hi", hi, 32'd0);
    check("rstmid_late_lo", lo, 32'd0);

    // Start pulsed while busy must be ignored
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) cyc++;
      if (i == 1) begin
        start = 1'b1; mdu_op = 3'd3; a = 32'd100; b = 32'd3;
      end else begin
        start = 1'b0; mdu_op = 3'd0;
      end
      @(negedge clk);
    end
`ifdef MDU_ZERO_LATENCY_EN
    check("ign_busy", 32'(cyc), 32'd0);
    check("ign_hi", hi, 32'd1);
    check("ign_lo", lo, 32'd33);
`else
    check("ign_busy", 32'(cyc), 32'd5);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd42);
`endif

    m_hi = hi;
    m_lo = lo;
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(rop, ra, rb, cyc);
      model_apply(rop, ra, rb);
      check($sformatf("rnd%0d_op%0d_busy", n, rop), 32'(cyc), 32'(exp_busy(rop)));
      check($sformatf("rnd%0d_op%0d_hi", n, rop), hi, m_hi);
      check($sformatf("rnd%0d_op%0d_lo", n, rop), lo, m_lo);
      read_hi = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("rnd%0d_mdout", n), md_out, read_hi ? m_hi : m_lo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
